// File: rtl/alu_pkg.sv
// Shared types for the RV32I multi-cycle core: ALU operations, datapath mux
// selects and the base opcodes the controller decodes.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic       {ADR_PC, ADR_ALUOUT}                alu_adr_dummy_t;
  typedef enum logic       {PC_ALU, PC_ALUOUT}                 pc_src_t;
  typedef enum logic [1:0] {A_PC, A_OLDPC, A_RS1, A_ZERO}      alu_a_sel_t;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR}              alu_b_sel_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;
  typedef enum logic [1:0] {WB_ALUOUT, WB_MDR, WB_PC}          wb_sel_t;
  typedef alu_adr_dummy_t adr_sel_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/alu_decoder.sv
// funct3/funct7 to ALU operation for R-type and OP-IMM instructions.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output alu_op_t    alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000: alu_op = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_op = ALU_SLL;
      3'b010: alu_op = ALU_SLT;
      3'b011: alu_op = ALU_SLTU;
      3'b100: alu_op = ALU_XOR;
      // SRAI shares IR[30] with SRA, so the shift type ignores is_rtype
      3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_op = ALU_OR;
      3'b111: alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I control FSM: sequences the shared ALU and unified memory
// port, driving every datapath enable and select each cycle.
module mc_controller
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output adr_sel_t   adr_sel,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       pc_we,
  output pc_src_t    pc_src,
  output alu_a_sel_t alu_a_sel,
  output alu_b_sel_t alu_b_sel,
  output imm_sel_t   imm_sel,
  output alu_op_t    alu_op,
  output logic       rf_we,
  output wb_sel_t    wb_sel,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_U, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JAL, S_JALR, S_TRAP
  } state_t;

  state_t  state_q, state_d;
  alu_op_t dec_op;

  alu_decoder u_alu_dec (
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .is_rtype (opcode == OP_R),
    .alu_op   (dec_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    adr_sel   = ADR_PC;
    ir_we     = 1'b0;
    mdr_we    = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_ALU;
    alu_a_sel = A_PC;
    alu_b_sel = B_RS2;
    imm_sel   = IMM_I;
    alu_op    = ALU_ADD;
    rf_we     = 1'b0;
    wb_sel    = WB_ALUOUT;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_b_sel = B_FOUR;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      // Speculatively form OLDPC+imm so BRANCH/JAL find the target in ALUOUT
      S_DECODE: begin
        alu_a_sel = A_OLDPC;
        alu_b_sel = B_IMM;
        imm_sel   = (opcode == OP_BRANCH) ? IMM_B : IMM_J;
        case (opcode)
          OP_R:              state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_EXEC_U;
          default:           state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_a_sel = A_RS1;
        alu_op    = dec_op;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_a_sel = A_RS1;
        alu_b_sel = B_IMM;
        alu_op    = dec_op;
        state_d   = S_WB_ALU;
      end
      S_EXEC_U: begin
        alu_a_sel = (opcode == OP_LUI) ? A_ZERO : A_OLDPC;
        alu_b_sel = B_IMM;
        imm_sel   = IMM_U;
        state_d   = S_WB_ALU;
      end
      S_WB_ALU: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_a_sel = A_RS1;
        alu_b_sel = B_IMM;
        imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_sel = ADR_ALUOUT;
        if (mem_ready) begin
          mdr_we  = 1'b1;
          state_d = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        rf_we   = 1'b1;
        wb_sel  = WB_MDR;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_sel = ADR_ALUOUT;
        if (mem_ready) state_d = S_FETCH;
      end
      // alu_zero here is the compare result of rs1 vs rs2 (SUB or SLT/SLTU)
      S_BRANCH: begin
        alu_a_sel = A_RS1;
        state_d   = S_FETCH;
        pc_src    = PC_ALUOUT;
        case (funct3)
          3'b000: begin alu_op = ALU_SUB;  pc_we = alu_zero;  end
          3'b001: begin alu_op = ALU_SUB;  pc_we = !alu_zero; end
          3'b100: begin alu_op = ALU_SLT;  pc_we = !alu_zero; end
          3'b101: begin alu_op = ALU_SLT;  pc_we = alu_zero;  end
          3'b110: begin alu_op = ALU_SLTU; pc_we = !alu_zero; end
          3'b111: begin alu_op = ALU_SLTU; pc_we = alu_zero;  end
          default: begin
            pc_src  = PC_ALU;
            state_d = S_TRAP;
          end
        endcase
        if (!pc_we) pc_src = PC_ALU;
      end
      S_JAL: begin
        rf_we   = 1'b1;
        wb_sel  = WB_PC;
        pc_we   = 1'b1;
        pc_src  = PC_ALUOUT;
        state_d = S_FETCH;
      end
      // Link value is the pre-update PC, captured on the same edge as PC load
      S_JALR: begin
        alu_a_sel = A_RS1;
        alu_b_sel = B_IMM;
        pc_we     = 1'b1;
        rf_we     = 1'b1;
        wb_sel    = WB_PC;
        state_d   = S_FETCH;
      end
      S_TRAP: illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // No request or write strobes may escape while reset is held
    if (!rst_n) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      mdr_we  = 1'b0;
      pc_we   = 1'b0;
      rf_we   = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed cycle-by-cycle check of every controller output across the
// RV32I instruction classes, memory waits, traps and reset.
module tb_mc_controller;
  import alu_pkg::*;

  logic       clk, rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, alu_zero, mem_ready;
  logic       mem_req, mem_we, ir_we, mdr_we, pc_we, rf_we, illegal;
  adr_sel_t   adr_sel;
  pc_src_t    pc_src;
  alu_a_sel_t alu_a_sel;
  alu_b_sel_t alu_b_sel;
  imm_sel_t   imm_sel;
  alu_op_t    alu_op;
  wb_sel_t    wb_sel;

  typedef struct packed {
    logic       req;
    logic       we;
    adr_sel_t   adr;
    logic       ir;
    logic       mdr;
    logic       pcw;
    pc_src_t    pcs;
    alu_a_sel_t a;
    alu_b_sel_t b;
    imm_sel_t   imm;
    alu_op_t    op;
    logic       rf;
    wb_sel_t    wb;
    logic       ill;
  } ctl_t;

  ctl_t obs;
  int   ntests = 0;
  int   nfail  = 0;

  assign obs = {mem_req, mem_we, adr_sel, ir_we, mdr_we, pc_we, pc_src,
                alu_a_sel, alu_b_sel, imm_sel, alu_op, rf_we, wb_sel, illegal};

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_sel(adr_sel), .ir_we(ir_we),
    .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .imm_sel(imm_sel), .alu_op(alu_op),
    .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t dflt();
    ctl_t c;
    c = '0;
    c.adr = ADR_PC; c.pcs = PC_ALU; c.a = A_PC; c.b = B_RS2;
    c.imm = IMM_I; c.op = ALU_ADD; c.wb = WB_ALUOUT;
    return c;
  endfunction

  function automatic ctl_t fetch(input logic rdy);
    ctl_t c = dflt();
    c.req = 1'b1; c.b = B_FOUR;
    c.ir = rdy; c.pcw = rdy;
    return c;
  endfunction

  function automatic ctl_t decode(input logic br);
    ctl_t c = dflt();
    c.a = A_OLDPC; c.b = B_IMM; c.imm = br ? IMM_B : IMM_J;
    return c;
  endfunction

  function automatic ctl_t ex(input alu_a_sel_t a, input alu_b_sel_t b,
                              input imm_sel_t imm, input alu_op_t op);
    ctl_t c = dflt();
    c.a = a; c.b = b; c.imm = imm; c.op = op;
    return c;
  endfunction

  function automatic ctl_t wb(input wb_sel_t s);
    ctl_t c = dflt();
    c.rf = 1'b1; c.wb = s;
    return c;
  endfunction

  function automatic ctl_t memc(input logic we, input logic mdr);
    ctl_t c = dflt();
    c.req = 1'b1; c.adr = ADR_ALUOUT; c.we = we; c.mdr = mdr;
    return c;
  endfunction

  function automatic ctl_t br(input alu_op_t op, input logic taken);
    ctl_t c = ex(A_RS1, B_RS2, IMM_I, op);
    c.pcw = taken; c.pcs = taken ? PC_ALUOUT : PC_ALU;
    return c;
  endfunction

  function automatic ctl_t trap();
    ctl_t c = dflt();
    c.ill = 1'b1;
    return c;
  endfunction

  // Called at posedge+1 with inputs already set; checks, then advances a cycle
  task automatic step(input ctl_t e, input string tag);
    #1;
    ntests++;
    assert (obs === e) else begin
      nfail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic rst_chk(input string tag);
    #1;
    ntests++;
    assert ({mem_req, mem_we, ir_we, mdr_we, pc_we, rf_we, illegal} === 7'b0) else begin
      nfail++;
      $error("FAIL %s enables=%b exp=0000000", tag,
             {mem_req, mem_we, ir_we, mdr_we, pc_we, rf_we, illegal});
    end
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7_5 = f7;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; alu_zero = 1'b0;
    set_ir(OP_R, 3'b000, 1'b0);
    rst_chk("reset_hold");
    release_rst();
    step(fetch(1'b0), "reset_fetch");

    // ADD
    mem_ready = 1'b1;
    step(fetch(1'b1), "add_fetch");
    step(decode(1'b0), "add_decode");
    step(ex(A_RS1, B_RS2, IMM_I, ALU_ADD), "add_exec");
    step(wb(WB_ALUOUT), "add_wb");

    // SUB, ADDI with IR[30]=1, SRAI
    set_ir(OP_R, 3'b000, 1'b1);
    step(fetch(1'b1), "sub_fetch");
    step(decode(1'b0), "sub_decode");
    step(ex(A_RS1, B_RS2, IMM_I, ALU_SUB), "sub_exec");
    step(wb(WB_ALUOUT), "sub_wb");
    set_ir(OP_IMM, 3'b000, 1'b1);
    step(fetch(1'b1), "addi_fetch");
    step(decode(1'b0), "addi_decode");
    step(ex(A_RS1, B_IMM, IMM_I, ALU_ADD), "addi_exec");
    step(wb(WB_ALUOUT), "addi_wb");
    set_ir(OP_IMM, 3'b101, 1'b1);
    step(fetch(1'b1), "srai_fetch");
    step(decode(1'b0), "srai_decode");
    step(ex(A_RS1, B_IMM, IMM_I, ALU_SRA), "srai_exec");
    step(wb(WB_ALUOUT), "srai_wb");

    // LW with 3 wait cycles in MEM_RD
    set_ir(OP_LOAD, 3'b010, 1'b0);
    step(fetch(1'b1), "lw_fetch");
    step(decode(1'b0), "lw_decode");
    step(ex(A_RS1, B_IMM, IMM_I, ALU_ADD), "lw_addr");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(memc(1'b0, 1'b0), "lw_wait");
    mem_ready = 1'b1;
    step(memc(1'b0, 1'b1), "lw_ready");
    step(wb(WB_MDR), "lw_wb");

    // SW with one fetch wait, zero-wait store
    set_ir(OP_STORE, 3'b010, 1'b0);
    mem_ready = 1'b0;
    step(fetch(1'b0), "sw_fetch_wait");
    mem_ready = 1'b1;
    step(fetch(1'b1), "sw_fetch");
    step(decode(1'b0), "sw_decode");
    step(ex(A_RS1, B_IMM, IMM_S, ALU_ADD), "sw_addr");
    step(memc(1'b1, 1'b0), "sw_write");

    // Branches
    set_ir(OP_BRANCH, 3'b111, 1'b0); alu_zero = 1'b1;
    step(fetch(1'b1), "bgeu_fetch");
    step(decode(1'b1), "bgeu_decode");
    step(br(ALU_SLTU, 1'b1), "bgeu_taken");
    set_ir(OP_BRANCH, 3'b001, 1'b0); alu_zero = 1'b0;
    step(fetch(1'b1), "bne_fetch");
    step(decode(1'b1), "bne_decode");
    step(br(ALU_SUB, 1'b1), "bne_taken");
    set_ir(OP_BRANCH, 3'b000, 1'b0); alu_zero = 1'b0;
    step(fetch(1'b1), "beq_fetch");
    step(decode(1'b1), "beq_decode");
    step(br(ALU_SUB, 1'b0), "beq_not_taken");
    set_ir(OP_BRANCH, 3'b100, 1'b0); alu_zero = 1'b1;
    step(fetch(1'b1), "blt_fetch");
    step(decode(1'b1), "blt_decode");
    step(br(ALU_SLT, 1'b0), "blt_not_taken");

    // JAL, JALR
    set_ir(OP_JAL, 3'b000, 1'b0);
    step(fetch(1'b1), "jal_fetch");
    step(decode(1'b0), "jal_decode");
    begin
      ctl_t e = wb(WB_PC);
      e.pcw = 1'b1; e.pcs = PC_ALUOUT;
      step(e, "jal_exec");
    end
    set_ir(OP_JALR, 3'b000, 1'b0);
    step(fetch(1'b1), "jalr_fetch");
    step(decode(1'b0), "jalr_decode");
    begin
      ctl_t e = ex(A_RS1, B_IMM, IMM_I, ALU_ADD);
      e.pcw = 1'b1; e.pcs = PC_ALU; e.rf = 1'b1; e.wb = WB_PC;
      step(e, "jalr_exec");
    end

    // LUI, AUIPC
    set_ir(OP_LUI, 3'b000, 1'b0);
    step(fetch(1'b1), "lui_fetch");
    step(decode(1'b0), "lui_decode");
    step(ex(A_ZERO, B_IMM, IMM_U, ALU_ADD), "lui_exec");
    step(wb(WB_ALUOUT), "lui_wb");
    set_ir(OP_AUIPC, 3'b000, 1'b0);
    step(fetch(1'b1), "auipc_fetch");
    step(decode(1'b0), "auipc_decode");
    step(ex(A_OLDPC, B_IMM, IMM_U, ALU_ADD), "auipc_exec");
    step(wb(WB_ALUOUT), "auipc_wb");

    // Unsupported opcode traps until reset
    set_ir(7'b0000000, 3'b000, 1'b0);
    step(fetch(1'b1), "trap_fetch");
    step(decode(1'b0), "trap_decode");
    for (int i = 0; i < 11; i++) step(trap(), "trap_hold");
    rst_n = 1'b0; mem_ready = 1'b1;
    rst_chk("trap_reset");
    release_rst();

    // Branch funct3 010 is not a branch
    set_ir(OP_BRANCH, 3'b010, 1'b0);
    step(fetch(1'b0), "bbad_fetch_wait");
    mem_ready = 1'b1;
    step(fetch(1'b1), "bbad_fetch");
    step(decode(1'b1), "bbad_decode");
    step(br(ALU_ADD, 1'b0), "bbad_branch");
    step(trap(), "bbad_trap");
    step(trap(), "bbad_trap2");
    rst_n = 1'b0;
    rst_chk("bbad_reset");
    release_rst();

    // Reset pulsed during a FETCH wait
    set_ir(OP_R, 3'b000, 1'b0);
    step(fetch(1'b0), "mid_fetch_wait");
    rst_n = 1'b0; mem_ready = 1'b1;
    rst_chk("mid_reset");
    release_rst();
    step(fetch(1'b0), "mid_resume_wait");
    mem_ready = 1'b1;
    step(fetch(1'b1), "mid_resume_fetch");
    step(decode(1'b0), "mid_resume_decode");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
